// File: rtl/shift_frame_pkg.sv
// Shared constants and state type for the 16-state serial capture frame sequencer.
package shift_frame_pkg;

  localparam int unsigned FRAME_BITS = 12;

  typedef logic [3:0] frame_state_t;

  localparam frame_state_t ST_IDLE        = 4'd0;
  localparam frame_state_t ST_SETUP       = 4'd1;
  localparam frame_state_t ST_SHIFT_FIRST = 4'd2;
  localparam frame_state_t ST_SHIFT_LAST  = 4'd13;
  localparam frame_state_t ST_LATCH       = 4'd14;
  localparam frame_state_t ST_DONE        = 4'd15;

  function automatic logic is_shift(input frame_state_t s);
    return (s >= ST_SHIFT_FIRST) && (s <= ST_SHIFT_LAST);
  endfunction

endpackage

// File: rtl/shift_frame_sipo.sv
// 12-bit serial-in/parallel-out capture register; MSB_FIRST selects the shift direction.
module shift_frame_sipo
  import shift_frame_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  shift_en,
  input  logic                  sdata_in,
  output logic [FRAME_BITS-1:0] shreg
);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (shift_en) begin
      if (MSB_FIRST) shreg <= {shreg[FRAME_BITS-2:0], sdata_in};
      else           shreg <= {sdata_in, shreg[FRAME_BITS-1:1]};
    end
  end

endmodule

// File: rtl/shift_frame_seq.sv
// Serial capture frame sequencer: start/busy/done handshake, 12-bit word capture.
// Optional FRAME_CNT_EN macro adds the frame_cnt completed-frame counter port.
module shift_frame_seq
  import shift_frame_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  sdata_in,
  output logic [3:0]            state,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] data_out,
  output logic                  data_valid
`ifdef FRAME_CNT_EN
  ,
  output logic [7:0]            frame_cnt
`endif
);

  frame_state_t          state_d;
  logic                  shift_en;
  logic                  latch_en;
  logic [FRAME_BITS-1:0] shreg;

  always_comb begin
    state_d  = state;
    shift_en = 1'b0;
    latch_en = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      // Every non-idle state simply advances; DONE wraps to IDLE by 4-bit overflow.
      if (state == ST_IDLE) begin
        if (start) state_d = ST_SETUP;
      end else begin
        state_d = state + 4'd1;
      end
      shift_en = is_shift(state);
      latch_en = (state == ST_LATCH);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_d;
      data_valid <= latch_en;
      if (latch_en) data_out <= shreg;
    end
  end

`ifdef FRAME_CNT_EN
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)        frame_cnt <= '0;
    else if (latch_en) frame_cnt <= frame_cnt + 8'd1;
  end
`endif

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  shift_frame_sipo #(
    .MSB_FIRST(MSB_FIRST)
  ) u_sipo (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .shift_en(shift_en),
    .sdata_in(sdata_in),
    .shreg   (shreg)
  );

endmodule

// File: tb/tb_shift_frame_seq.sv
// Scoreboard bench for shift_frame_seq: MSB-first and LSB-first instances share one stimulus stream.
module tb_shift_frame_seq;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        sdata_in = 1'b0;
  logic [3:0]  state_m, state_l;
  logic        busy_m, busy_l, done_m, done_l, dv_m, dv_l;
  logic [11:0] data_out_m, data_out_l;
`ifdef FRAME_CNT_EN
  logic [7:0]  frame_cnt_m, frame_cnt_l;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [11:0] q_m[$];
  logic [11:0] q_l[$];
  logic [11:0] last_m = '0;
  logic [11:0] last_l = '0;
  logic [7:0]  model_cnt = '0;

  always #5 clk_in = ~clk_in;

  shift_frame_seq #(.MSB_FIRST(1'b1)) u_msb (
    .clk_in(clk_in), .rst_n(rst_n), .start(start), .abort(abort), .sdata_in(sdata_in),
    .state(state_m), .busy(busy_m), .done(done_m), .data_out(data_out_m), .data_valid(dv_m)
`ifdef FRAME_CNT_EN
    , .frame_cnt(frame_cnt_m)
`endif
  );

  shift_frame_seq #(.MSB_FIRST(1'b0)) u_lsb (
    .clk_in(clk_in), .rst_n(rst_n), .start(start), .abort(abort), .sdata_in(sdata_in),
    .state(state_l), .busy(busy_l), .done(done_l), .data_out(data_out_l), .data_valid(dv_l)
`ifdef FRAME_CNT_EN
    , .frame_cnt(frame_cnt_l)
`endif
  );

  // First serial bit ends up in bit 0 when shifting LSB-first.
  function automatic logic [11:0] lsb_word(input logic [11:0] w);
    logic [11:0] r;
    for (int i = 0; i < 12; i++) r[i] = w[11-i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_word(input logic [11:0] w);
    q_m.push_back(w);
    q_l.push_back(lsb_word(w));
    last_m = w;
    last_l = lsb_word(w);
    model_cnt = model_cnt + 8'd1;
  endtask

  task automatic check_held(input string name);
    chk(name, 32'({data_out_m, data_out_l}), 32'({last_m, last_l}));
`ifdef FRAME_CNT_EN
    chk("frame_cnt", 32'({frame_cnt_m, frame_cnt_l}), 32'({model_cnt, model_cnt}));
`endif
  endtask

  // One frame from idle; abort_st is the state during which abort is raised (-1: none).
  task automatic frame(input logic [11:0] w, input int abort_st);
    int exp_st;
    if (!(abort_st >= 0 && abort_st <= 14)) expect_word(w);
    for (int k = 0; k < 16; k++) begin
      start    = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      abort    = (k == abort_st);
      sdata_in = (k >= 2 && k <= 13) ? w[13-k] : 1'($urandom_range(0, 1));
      tick;
      exp_st = (k == abort_st) ? 0 : (k + 1) % 16;
      chk("state_seq", 32'({state_m, state_l}), 32'({exp_st[3:0], exp_st[3:0]}));
      chk("busy", 32'({busy_m, busy_l}), (exp_st != 0) ? 32'd3 : 32'd0);
      if (k == 14 && abort_st != 14) chk("latch_pulse", 32'({dv_m, done_m, dv_l, done_l}), 32'hF);
      if (k == 15) chk("pulse_clear", 32'({dv_m, done_m, dv_l, done_l}), 32'h0);
      if (k == abort_st) break;
    end
    start = 1'b0;
    abort = 1'b0;
    check_held("held_word");
  endtask

  // start held high: back-to-back frames, exactly 16 cycles each.
  task automatic frames_hold(input int n);
    logic [11:0] w;
    int          k;
    w = '0;
    start = 1'b1;
    for (int c = 0; c < 16 * n; c++) begin
      k = c % 16;
      if (k == 0) begin
        w = 12'($urandom);
        expect_word(w);
      end
      sdata_in = (k >= 2 && k <= 13) ? w[13-k] : 1'($urandom_range(0, 1));
      tick;
      chk("hold_state", 32'(state_m), 32'((c + 1) % 16));
    end
    start = 1'b0;
    check_held("hold_word");
  endtask

  // Monitor: every data_valid pops one expected word.
  always @(negedge clk_in) begin
    if (rst_n && (dv_m || dv_l || done_m || done_l)) begin
      chk("pulse_set", 32'({dv_m, done_m, dv_l, done_l}), 32'hF);
      if (q_m.size() == 0 || q_l.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got word 0x%0h with empty queue at %0t", data_out_m, $time);
      end else begin
        chk("word_msb", 32'(data_out_m), 32'(q_m.pop_front()));
        chk("word_lsb", 32'(data_out_l), 32'(q_l.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int gap;
    int ab;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_zero", 32'({state_m, busy_m, done_m, dv_m, data_out_m}), 32'h0);
    @(negedge clk_in);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick;
      chk("idle_state", 32'({state_m, busy_m, dv_m, data_out_m}), 32'h0);
    end

    frame(12'hA5C, -1);
    chk("word_a5c", 32'(data_out_m), 32'h0A5C);
    chk("word_3a5", 32'(data_out_l), 32'h03A5);

    frames_hold(3);

    frame(12'h123, -1);
    frame(12'($urandom), 7);
    chk("abort_keep", 32'(data_out_m), 32'h0123);
    frame(12'($urandom), 14);
    frame(12'($urandom), 15);
    frame(12'($urandom), 0);

    for (int r = 0; r < 30; r++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick;
        chk("gap_idle", 32'(state_m), 32'h0);
      end
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      frame(12'($urandom), ab);
    end

    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    chk("pre_reset_state", 32'(state_m), 32'd10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", 32'({state_m, busy_m, done_m, dv_m, data_out_m, data_out_l}), 32'h0);
`ifdef FRAME_CNT_EN
    chk("async_rst_cnt", 32'({frame_cnt_m, frame_cnt_l}), 32'h0);
`endif
    last_m = '0;
    last_l = '0;
    model_cnt = '0;
    @(negedge clk_in);
    rst_n = 1'b1;
    tick;
    frame(12'($urandom), -1);

`ifdef FRAME_CNT_EN
    frames_hold(256);
`endif

    repeat (3) tick;
    chk("sb_drain", 32'(q_m.size() + q_l.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
